encoder_4to2_reg: RTL and testbench
===================================

# encoder_4to2_reg

Registered 4-to-2 priority encoder. It converts a 4-bit request vector into the 2-bit index of the winning request, plus a valid flag. The output registers update on every clock edge. It is a small leaf block for arbitration and interrupt-index paths, where a one-hot or multi-hot request word must become a binary index.

## Interface

Parameters:
- MSB_PRIORITY, default 1. When 1, the highest set bit wins. When 0, the lowest set bit wins.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; one clock, reset is synchronous and active-high.
- i  input  4  request vector; bit n set means request n is active.
- e  output  2  registered binary index of the winning request.
- v  output  1  registered valid; 1 when at least one bit of i was set.

## Operation

- Combinational winner selection, with MSB_PRIORITY=1:
  - i[3]=1 → 2'b11
  - else i[2]=1 → 2'b10
  - else i[1]=1 → 2'b01
  - else i[0]=1 → 2'b00
- Combinational winner selection, with MSB_PRIORITY=0:
  - i[0]=1 → 2'b00
  - else i[1]=1 → 2'b01
  - else i[2]=1 → 2'b10
  - else i[3]=1 → 2'b11
- Valid: next_v = |i, independent of MSB_PRIORITY.
- All-zero input: next_e = 2'b00 and next_v = 0. A consumer must qualify e with v, because e=00 with v=0 is distinct from request 0 winning.
- Multi-hot inputs are legal. Exactly one index is produced per the priority rule, with no error flag.
- X/Z on i is not supported. The bench drives only 0/1.
- No internal state other than the e and v registers. No enable; the registers load every cycle.

## Timing

- Latency: 1 clock. The e and v values after rising edge k reflect i sampled at edge k.
- Reset: while rst=1 at a rising edge, e <= 2'b00 and v <= 0. The i input is ignored during that cycle.
- Reset release: the first edge with rst=0 captures the current i. There is no extra dead cycle.
- Reset mid-stream: the cycle after the reset edge shows e=00, v=0, regardless of prior or current i.
- Outputs are glitch-free: they change only on clk rising edges.
- Throughput: one new input per cycle. Back-to-back changes on i each appear exactly one cycle later.

## Test plan

- Reset: hold rst=1 for 2 cycles with i=4'b1111 → e=00, v=0 after each edge. Release rst; the next edge gives e=11, v=1.
- Full descending sweep, MSB_PRIORITY=1: apply i = 1111, 1110, … 0001, 0000, one value per cycle. The result one cycle later must be:
  - i = 1111 … 1000 → e=11, v=1
  - i = 0111 … 0100 → e=10, v=1
  - i = 0011, 0010 → e=01, v=1
  - i = 0001 → e=00, v=1
  - i = 0000 → e=00, v=0
- One-hot walk: i = 0001, 0010, 0100, 1000 → e = 00, 01, 10, 11 with v=1, for both parameter values.
- LSB priority, MSB_PRIORITY=0: i = 1111 → 00; 1110 → 01; 1100 → 10; 1000 → 11; 0000 → e=00, v=0.
- Latency/throughput: toggle i between 1000 and 0001 every cycle → e alternates 11/00, lagging i by exactly one cycle.
- Mid-stream reset: during the sweep, assert rst for 1 cycle while i=0110 → that cycle's output is e=00, v=0. The following cycle resumes with the correct encoding of the then-current i.

Source files
------------

// File: rtl/encoder_4to2_reg.sv
// Registered 4-to-2 priority encoder.
// Turns a 4-bit request vector into the 2-bit index of the winning request
// plus a valid flag. The winner is the highest set bit when MSB_PRIORITY=1
// and the lowest set bit when MSB_PRIORITY=0. Both outputs are registered,
// giving one cycle of latency. Consumers must qualify e with v, because
// e=00 with v=0 (no request) is not the same as request 0 winning.
module encoder_4to2_reg #(
   parameter int MSB_PRIORITY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] i,
   output logic [1:0] e,
   output logic       v
);

   logic [1:0] w_e_next;
   logic       w_v_next;
   logic [1:0] r_e;
   logic       r_v;

   // Winner selection; an all-zero request falls through to index 00
   always_comb begin
      w_e_next = '0;
      w_v_next = |i;
      if (MSB_PRIORITY != 0) begin
         if (i[3])      w_e_next = 2'b11;
         else if (i[2]) w_e_next = 2'b10;
         else if (i[1]) w_e_next = 2'b01;
         else           w_e_next = 2'b00;
      end else begin
         if (i[0])      w_e_next = 2'b00;
         else if (i[1]) w_e_next = 2'b01;
         else if (i[2]) w_e_next = 2'b10;
         else if (i[3]) w_e_next = 2'b11;
         else           w_e_next = 2'b00;
      end
   end

   // Output registers load every cycle; synchronous reset clears them
   always_ff @(posedge clk) begin
      if (rst) begin
         r_e <= '0;
         r_v <= 1'b0;
      end else begin
         r_e <= w_e_next;
         r_v <= w_v_next;
      end
   end

   assign e = r_e;
   assign v = r_v;

endmodule

// File: tb/tb_encoder_4to2_reg.sv
// Bench for encoder_4to2_reg: one instance per priority setting, shared
// stimulus. Each issued vector pushes its hand-computed expected outputs
// into a queue; a monitor pops one entry per clock edge and compares.
module tb_encoder_4to2_reg;

   typedef struct packed {
      logic [1:0] em;   // expected e, MSB priority instance
      logic [1:0] el;   // expected e, LSB priority instance
      logic       ev;   // expected v, both instances
      logic [3:0] vi;   // stimulus, for reporting
      logic       vr;   // reset, for reporting
   } exp_t;

   logic       clk;
   logic       rst;
   logic [3:0] i;
   logic [1:0] e_msb, e_lsb;
   logic       v_msb, v_lsb;

   exp_t q[$];
   int   checks;
   int   failures;
   int   n_issued;

   encoder_4to2_reg #(.MSB_PRIORITY(1)) u_msb (
      .clk (clk),
      .rst (rst),
      .i   (i),
      .e   (e_msb),
      .v   (v_msb)
   );

   encoder_4to2_reg #(.MSB_PRIORITY(0)) u_lsb (
      .clk (clk),
      .rst (rst),
      .i   (i),
      .e   (e_lsb),
      .v   (v_lsb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one vector for the next rising edge and record its expectation
   task automatic vec(input logic r, input logic [3:0] vi,
                      input logic [1:0] em, input logic [1:0] el,
                      input logic ev);
      exp_t x;
      @(negedge clk);
      rst = r;
      i   = vi;
      x.em = em; x.el = el; x.ev = ev; x.vi = vi; x.vr = r;
      q.push_back(x);
      n_issued++;
   endtask

   // Monitor: one expectation per rising edge, sampled 1 time unit later
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            x = q.pop_front();
            checks++;
            if (e_msb !== x.em) begin
               failures++;
               $display("FAIL msb_e rst=%b i=%b got=%b exp=%b", x.vr, x.vi, e_msb, x.em);
            end
            checks++;
            if (v_msb !== x.ev) begin
               failures++;
               $display("FAIL msb_v rst=%b i=%b got=%b exp=%b", x.vr, x.vi, v_msb, x.ev);
            end
            checks++;
            if (e_lsb !== x.el) begin
               failures++;
               $display("FAIL lsb_e rst=%b i=%b got=%b exp=%b", x.vr, x.vi, e_lsb, x.el);
            end
            checks++;
            if (v_lsb !== x.ev) begin
               failures++;
               $display("FAIL lsb_v rst=%b i=%b got=%b exp=%b", x.vr, x.vi, v_lsb, x.ev);
            end
         end
      end
   end

   initial begin
      int budget;
      checks   = 0;
      failures = 0;
      n_issued = 0;
      rst = 1'b1;
      i   = 4'b0000;

      //   rst  i        e_msb  e_lsb  v
      // reset held two cycles with all requests active
      vec(1, 4'b1111, 2'b00, 2'b00, 0);
      vec(1, 4'b1111, 2'b00, 2'b00, 0);
      // release: first edge captures i directly
      vec(0, 4'b1111, 2'b11, 2'b00, 1);
      // descending sweep
      vec(0, 4'b1110, 2'b11, 2'b01, 1);
      vec(0, 4'b1101, 2'b11, 2'b00, 1);
      vec(0, 4'b1100, 2'b11, 2'b10, 1);
      vec(0, 4'b1011, 2'b11, 2'b00, 1);
      vec(0, 4'b1010, 2'b11, 2'b01, 1);
      vec(0, 4'b1001, 2'b11, 2'b00, 1);
      vec(0, 4'b1000, 2'b11, 2'b11, 1);
      vec(0, 4'b0111, 2'b10, 2'b00, 1);
      vec(0, 4'b0110, 2'b10, 2'b01, 1);
      vec(0, 4'b0101, 2'b10, 2'b00, 1);
      vec(0, 4'b0100, 2'b10, 2'b10, 1);
      vec(0, 4'b0011, 2'b01, 2'b00, 1);
      vec(0, 4'b0010, 2'b01, 2'b01, 1);
      vec(0, 4'b0001, 2'b00, 2'b00, 1);
      vec(0, 4'b0000, 2'b00, 2'b00, 0);
      // one-hot walk
      vec(0, 4'b0001, 2'b00, 2'b00, 1);
      vec(0, 4'b0010, 2'b01, 2'b01, 1);
      vec(0, 4'b0100, 2'b10, 2'b10, 1);
      vec(0, 4'b1000, 2'b11, 2'b11, 1);
      // back-to-back toggling, one cycle lag
      vec(0, 4'b0001, 2'b00, 2'b00, 1);
      vec(0, 4'b1000, 2'b11, 2'b11, 1);
      vec(0, 4'b0001, 2'b00, 2'b00, 1);
      vec(0, 4'b1000, 2'b11, 2'b11, 1);
      vec(0, 4'b0001, 2'b00, 2'b00, 1);
      // mid-stream reset while i=0110, then resume
      vec(0, 4'b0111, 2'b10, 2'b00, 1);
      vec(1, 4'b0110, 2'b00, 2'b00, 0);
      vec(0, 4'b0101, 2'b10, 2'b00, 1);
      vec(0, 4'b1100, 2'b11, 2'b10, 1);
      // all-zero after valid traffic
      vec(0, 4'b0000, 2'b00, 2'b00, 0);
      vec(0, 4'b0010, 2'b01, 2'b01, 1);

      // drain with a bounded wait
      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #2;
      if (q.size() > 0) begin
         failures++;
         $display("FAIL drain pending=%0d exp=0", q.size());
      end
      if (checks != 4 * n_issued) begin
         failures++;
         $display("FAIL check_count got=%0d exp=%0d", checks, 4 * n_issued);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
